// File: rtl/bus_xfer_seq.sv
// Bus transfer sequencer: accepts a source/destination code pair and runs a
// fixed DRIVE -> LOAD -> DONE sequence of one-hot bus-driver and load strobes.
module bus_xfer_seq #(
    parameter int unsigned SRC_N = 24,
    parameter int unsigned DST_N = 24
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_src,
    input  logic [4:0]       req_dst,
    output logic [SRC_N-1:0] out_en,
    output logic [DST_N-1:0] in_en,
    output logic             done,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] SRC_LIM = 6'(SRC_N);
    localparam logic [5:0] DST_LIM = 6'(DST_N);

    state_t           state_q,  state_d;
    logic [4:0]       src_q,    src_d;
    logic [4:0]       dst_q,    dst_d;
    logic [SRC_N-1:0] out_en_q, out_en_d;
    logic [DST_N-1:0] in_en_q,  in_en_d;
    logic             done_q,   done_d;
    logic             err_q,    err_d;
    logic             busy_q,   busy_d;
    logic             req_legal;

    function automatic logic [SRC_N-1:0] src_onehot(input logic [4:0] code);
        logic [SRC_N-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < SRC_N; i++) begin
            if (code == 5'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [DST_N-1:0] dst_onehot(input logic [4:0] code);
        logic [DST_N-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DST_N; i++) begin
            if (code == 5'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign req_legal = ({1'b0, req_src} < SRC_LIM) && ({1'b0, req_dst} < DST_LIM);
    assign req_ready = (state_q == S_IDLE);

    // Strobes are computed one state ahead so every output leaves a flop.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        out_en_d = '0;
        in_en_d  = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        busy_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    src_d = req_src;
                    dst_d = req_dst;
                    if (req_legal) begin
                        state_d  = S_DRIVE;
                        out_en_d = src_onehot(req_src);
                        busy_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DRIVE: begin
                state_d  = S_LOAD;
                out_en_d = src_onehot(src_q);
                in_en_d  = dst_onehot(dst_q);
                busy_d   = 1'b1;
            end
            S_LOAD: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            out_en_q <= '0;
            in_en_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            out_en_q <= out_en_d;
            in_en_q  <= in_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign out_en = out_en_q;
    assign in_en  = in_en_q;
    assign done   = done_q;
    assign err    = err_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Self-checking bench for bus_xfer_seq: vector table, hand-written corner
// sequences and a randomized run against a cycle-timeline reference model.
module tb_bus_xfer_seq;

    logic        clk;
    logic        clear_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_src;
    logic [4:0]  req_dst;
    logic [23:0] out_en;
    logic [23:0] in_en;
    logic        done;
    logic        err;
    logic        busy;

    int n_assert;
    int n_fail;

    bus_xfer_seq #(.SRC_N(24), .DST_N(24)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .out_en    (out_en),
        .in_en     (in_en),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] oh(input logic [4:0] code);
        logic [23:0] one;
        one = 24'h1;
        return (code < 5'd24) ? (one << code) : 24'h0;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (req_ready) break;
            tick();
        end
        chk("wait_ready", {31'b0, req_ready}, 32'd1);
    endtask

    // Strobe invariants, every cycle while out of reset
    always @(negedge clk) begin
        if (clear_n) begin
            chk("inv_out_onehot", {31'b0, ($countones(out_en) <= 1)}, 32'd1);
            chk("inv_in_onehot",  {31'b0, ($countones(in_en)  <= 1)}, 32'd1);
            chk("inv_in_needs_out", {31'b0, (in_en == 24'h0 || out_en != 24'h0)}, 32'd1);
        end
    end

    typedef struct {
        logic [4:0]  src;
        logic [4:0]  dst;
        logic [23:0] exp_out;
        logic [23:0] exp_in;
        logic        exp_err;
    } vec_t;

    vec_t tbl[8];

    localparam int RMAX = 2100;
    logic [23:0] m_out  [RMAX];
    logic [23:0] m_in   [RMAX];
    logic        m_done [RMAX];
    logic        m_err  [RMAX];
    logic        m_busy [RMAX];

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        clear_n   = 1'b0;
        req_valid = 1'b0;
        req_src   = 5'd0;
        req_dst   = 5'd0;

        tbl[0] = '{5'd1,  5'd2,  24'h000002, 24'h000004, 1'b0};
        tbl[1] = '{5'd19, 5'd19, 24'h080000, 24'h080000, 1'b0};
        tbl[2] = '{5'd23, 5'd23, 24'h800000, 24'h800000, 1'b0};
        tbl[3] = '{5'd5,  5'd5,  24'h000020, 24'h000020, 1'b0};
        tbl[4] = '{5'd24, 5'd0,  24'h000000, 24'h000000, 1'b1};
        tbl[5] = '{5'd0,  5'd31, 24'h000000, 24'h000000, 1'b1};
        tbl[6] = '{5'd0,  5'd0,  24'h000001, 24'h000001, 1'b0};
        tbl[7] = '{5'd16, 5'd17, 24'h010000, 24'h020000, 1'b0};

        // Reset state
        #12;
        chk("rst_out_en", {8'b0, out_en}, 32'h0);
        chk("rst_in_en",  {8'b0, in_en},  32'h0);
        chk("rst_done",   {31'b0, done},  32'd0);
        chk("rst_err",    {31'b0, err},   32'd0);
        chk("rst_busy",   {31'b0, busy},  32'd0);
        clear_n = 1'b1;
        tick();
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        // Table-driven single transfers
        foreach (tbl[k]) begin
            wait_ready();
            req_src   = tbl[k].src;
            req_dst   = tbl[k].dst;
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            if (tbl[k].exp_err) begin
                chk("tbl_err",      {31'b0, err},    32'd1);
                chk("tbl_err_out",  {8'b0, out_en},  32'h0);
                chk("tbl_err_in",   {8'b0, in_en},   32'h0);
                chk("tbl_err_busy", {31'b0, busy},   32'd0);
                chk("tbl_err_rdy",  {31'b0, req_ready}, 32'd1);
                tick();
                chk("tbl_err_pulse", {31'b0, err},  32'd0);
                chk("tbl_err_nodone", {31'b0, done}, 32'd0);
            end else begin
                chk("tbl_drive_out", {8'b0, out_en}, {8'b0, tbl[k].exp_out});
                chk("tbl_drive_in",  {8'b0, in_en},  32'h0);
                chk("tbl_drive_busy", {31'b0, busy}, 32'd1);
                chk("tbl_drive_rdy", {31'b0, req_ready}, 32'd0);
                tick();
                chk("tbl_load_out",  {8'b0, out_en}, {8'b0, tbl[k].exp_out});
                chk("tbl_load_in",   {8'b0, in_en},  {8'b0, tbl[k].exp_in});
                tick();
                chk("tbl_done",      {31'b0, done},  32'd1);
                chk("tbl_done_out",  {8'b0, out_en}, 32'h0);
                chk("tbl_done_in",   {8'b0, in_en},  32'h0);
                tick();
                chk("tbl_idle_done", {31'b0, done},  32'd0);
                chk("tbl_idle_rdy",  {31'b0, req_ready}, 32'd1);
                chk("tbl_idle_busy", {31'b0, busy},  32'd0);
            end
        end

        // Asynchronous reset in the middle of LOAD
        wait_ready();
        req_src = 5'd1; req_dst = 5'd2; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("midrst_pre_in", {8'b0, in_en}, 32'h000004);
        clear_n = 1'b0;
        #1;
        chk("midrst_out", {8'b0, out_en}, 32'h0);
        chk("midrst_in",  {8'b0, in_en},  32'h0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        #10;
        clear_n = 1'b1;
        tick();
        chk("midrst_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_busy",  {31'b0, busy},  32'd0);
        tick();
        chk("midrst_nodone", {31'b0, done}, 32'd0);

        // Glitch on req_valid between edges is ignored
        #2 req_valid = 1'b1;
        #2 req_valid = 1'b0;
        tick();
        chk("glitch_busy", {31'b0, busy}, 32'd0);
        chk("glitch_out",  {8'b0, out_en}, 32'h0);

        // Back-to-back with held valid; code changes while busy are ignored
        begin
            int t_done1;
            int t_done2;
            t_done1 = -1;
            t_done2 = -1;
            wait_ready();
            req_src = 5'd1; req_dst = 5'd2; req_valid = 1'b1;
            tick();
            req_src = 5'd2; req_dst = 5'd3;
            for (int c = 1; c <= 8; c++) begin
                if (c == 1) chk("b2b_t0_out", {8'b0, out_en}, 32'h000002);
                if (c == 2) begin
                    chk("b2b_t1_out", {8'b0, out_en}, 32'h000002);
                    chk("b2b_t1_in",  {8'b0, in_en},  32'h000004);
                end
                if (c == 5) begin
                    chk("b2b_t4_out", {8'b0, out_en}, 32'h000004);
                    req_valid = 1'b0;
                end
                if (c == 6) chk("b2b_t5_in", {8'b0, in_en}, 32'h000008);
                if (done && t_done1 < 0) t_done1 = c;
                else if (done && t_done2 < 0) t_done2 = c;
                tick();
            end
            chk("b2b_done1_seen", {31'b0, (t_done1 >= 0)}, 32'd1);
            chk("b2b_done_gap", 32'(t_done2 - t_done1), 32'd4);
        end

        // Illegal request then legal one accepted on the very next edge
        wait_ready();
        req_src = 5'd24; req_dst = 5'd0; req_valid = 1'b1;
        tick();
        chk("ill_err", {31'b0, err}, 32'd1);
        chk("ill_rdy", {31'b0, req_ready}, 32'd1);
        req_src = 5'd23; req_dst = 5'd23;
        tick();
        req_valid = 1'b0;
        chk("ill_err_clr", {31'b0, err}, 32'd0);
        chk("ill_next_out", {8'b0, out_en}, 32'h800000);
        tick();
        chk("ill_next_in", {8'b0, in_en}, 32'h800000);
        tick();
        chk("ill_next_done", {31'b0, done}, 32'd1);
        tick();

        // Randomized run against a cycle-timeline model
        begin
            int e;
            int free_at;
            int accepted;
            logic v;
            logic [4:0] s;
            logic [4:0] d;
            for (int i = 0; i < RMAX; i++) begin
                m_out[i] = '0; m_in[i] = '0;
                m_done[i] = 1'b0; m_err[i] = 1'b0; m_busy[i] = 1'b0;
            end
            e = 0; free_at = 0; accepted = 0;
            while (accepted < 200 && e < 2000) begin
                v = ($urandom_range(0, 2) != 0);
                s = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
                d = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
                req_valid = v; req_src = s; req_dst = d;
                chk("rnd_ready", {31'b0, req_ready}, {31'b0, (e >= free_at)});
                if (v && e >= free_at) begin
                    accepted++;
                    if (s < 5'd24 && d < 5'd24) begin
                        m_out[e] = oh(s); m_out[e+1] = oh(s);
                        m_in[e+1] = oh(d);
                        m_done[e+2] = 1'b1;
                        m_busy[e] = 1'b1; m_busy[e+1] = 1'b1; m_busy[e+2] = 1'b1;
                        free_at = e + 4;
                    end else begin
                        m_err[e] = 1'b1;
                    end
                end
                tick();
                chk("rnd_out",  {8'b0, out_en}, {8'b0, m_out[e]});
                chk("rnd_in",   {8'b0, in_en},  {8'b0, m_in[e]});
                chk("rnd_done", {31'b0, done},  {31'b0, m_done[e]});
                chk("rnd_err",  {31'b0, err},   {31'b0, m_err[e]});
                chk("rnd_busy", {31'b0, busy},  {31'b0, m_busy[e]});
                e++;
            end
            chk("rnd_accepted", {31'b0, (accepted == 200)}, 32'd1);
            req_valid = 1'b0;
            for (int i = 0; i < 5; i++) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_xfer_seq.md
# bus_xfer_seq

Control-side sequencer for the 32-bit datapath bus: it is the initiator that generates the one-hot source-select strobes the bus multiplexer encodes, plus the matching destination load strobes. A requester (control unit or bench) hands it a source code and destination code over a valid/ready handshake. It then runs a fixed drive/load sequence guaranteeing exactly one bus driver and one loader per transfer, and returns a done pulse or an error pulse.

## Interface
- SRC_N, 24: number of bus sources. Codes 0–15 = R0–R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C_sign_extended.
- DST_N, 24: number of bus destinations. Codes 0–15 = R0–R15, 16 HI, 17 LO, 18 Y, 19 MAR, 20 PC, 21 MDR, 22 IR, 23 OutPort.
- clk  in  1  single clock; all state changes on rising edge.
- clear_n  in  1  asynchronous active-low reset.
- req_valid  in  1  transfer request present.
- req_ready  out  1  sequencer can accept a request.
- req_src  in  5  source code.
- req_dst  in  5  destination code.
- out_en  out  SRC_N  one-hot bus-driver select (bit i = source i "out" strobe).
- in_en  out  DST_N  one-hot destination load strobe (bit j = destination j "in").
- done  out  1  one-cycle pulse: transfer completed.
- err  out  1  one-cycle pulse: request rejected (illegal code).
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, DRIVE, LOAD, DONE.
- IDLE: req_ready=1. On req_valid && req_ready, latch src/dst into internal registers.
  - Either code ≥ 24: no strobes; err=1 next cycle; stay IDLE.
  - Otherwise go to DRIVE.
- DRIVE (1 cycle): out_en = one-hot(src_q), in_en = 0. Bus settles.
- LOAD (1 cycle): out_en held, in_en = one-hot(dst_q). Destination captures bus on the rising edge ending this cycle.
- DONE (1 cycle): out_en=0, in_en=0, done=1. Next state IDLE.
- req_ready=1 only in IDLE. A request presented while busy is not accepted; the requester must hold req_valid.
- All outputs are registered (Moore). popcount(out_en) ≤ 1 and popcount(in_en) ≤ 1 in every cycle.
- in_en is never asserted unless out_en is asserted in the same cycle.
- Latched codes do not change between acceptance and DONE, regardless of req_src/req_dst activity.
- src == dst numerically is legal: the code spaces are separate, e.g. src 5/dst 5 is R5→R5.

## Timing
- Reset (clear_n low, asynchronous):
  - state=IDLE, out_en=0, in_en=0, done=0, err=0, busy=0, latched codes=0.
  - req_ready=1 once clear_n is released.
- Accept edge is T0. Then:
  - T0→T1: DRIVE; out_en valid, busy=1.
  - T1→T2: LOAD; in_en valid.
  - T2→T3: DONE; done=1.
  - T3: IDLE; req_ready=1.
- Fixed latency: 3 cycles from accept to done. Throughput: one transfer per 4 cycles.
- Back-to-back: a request held valid through DONE is accepted on the first IDLE edge.
- Illegal request: err high for exactly the cycle after the accept edge. req_ready stays 1, so a new request is accepted on that same next edge.
- Reset mid-transfer: all strobes drop immediately, without waiting for clk. The transfer is aborted with no done or err.
- req_valid is sampled only at rising edges; glitches between edges have no effect.

## Test plan
- Reset: clear_n=0 mid-LOAD, src=1/dst=2 → out_en, in_en and done go to 0 asynchronously; after release, req_ready=1 and busy=0.
- Basic R1→R2, req_src=1, req_dst=2:
  - DRIVE: out_en=24'h000002, in_en=0.
  - LOAD: out_en=24'h000002, in_en=24'h000004.
  - DONE: done=1.
- Special codes, src=19 (Zlow) → dst=19 (MAR): out_en=24'h080000 in DRIVE and LOAD; in_en=24'h080000 in LOAD only; done 3 cycles after accept.
- Illegal code, req_src=24 → err=1 for one cycle; out_en and in_en stay 0; no done.
  - Then src=23/dst=23 accepted next edge → out_en=24'h800000, done 3 cycles later.
- Back-to-back: hold req_valid with R1→R2, then R2→R3 → two done pulses 4 cycles apart.
  - Second transfer shows out_en=24'h000004, in_en=24'h000008.
  - req_src changes during busy are ignored.
- One-hot invariant: 200 random legal/illegal requests → checker asserts popcount ≤ 1 for both strobe vectors every cycle, and in_en ≠ 0 ⇒ out_en ≠ 0.
